// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the write-back trace buffer: entry kinds, FSM states,
// the default end-of-program word and the packed payload of one trace entry.
package cpu_trace_pkg;

  localparam logic [1:0] TR_REG  = 2'b01;
  localparam logic [1:0] TR_MEM  = 2'b10;
  localparam logic [1:0] TR_BOTH = 2'b11;

  localparam logic [31:0] HALT_INST_DEF = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } trace_state_e;

  // Payload of one entry; the cycle stamp is prepended by the top because its
  // width is a parameter of the block.
  typedef struct packed {
    logic [1:0]  kind;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
  } trace_payload_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with show-ahead output. Output data is forced to zero while
// empty so that stale storage never appears on the read port.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  // Flags, accepted push/pop, pointer and occupancy next state.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == FULL_CNT);
    do_pop   = pop && !empty;
    // A push into a full FIFO is only accepted when a pop frees the slot.
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = din;
    dout  = empty ? '0 : mem_q[rd_ptr_q];
    count = count_q;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are irrelevant while the pointers say empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// Snoops the WB register write and MEM store ports, records each architectural
// write with a cycle stamp into a FIFO, and raises HALTED once the end-of-program
// instruction has been fetched and the pipeline behind it has drained.
module wb_trace_buffer import cpu_trace_pkg::*; #(
  parameter int          DEPTH        = 16,
  parameter int          CYC_W        = 16,
  parameter logic [31:0] HALT_INST    = HALT_INST_DEF,
  parameter int          DRAIN_CYCLES = 4
) (
  input  logic                   CLOCK,
  input  logic                   RESET,
  input  logic                   REG_WEN_W,
  input  logic [4:0]             REG_ADDR_W,
  input  logic [31:0]            REG_DATA_W,
  input  logic                   MEM_WEN_M,
  input  logic [31:0]            MEM_ADDR_M,
  input  logic [31:0]            MEM_DATA_M,
  input  logic [31:0]            INST_F,
  input  logic                   TR_READY,
  output logic                   TR_VALID,
  output logic [1:0]             TR_KIND,
  output logic [CYC_W-1:0]       TR_CYCLE,
  output logic [4:0]             TR_REG_ADDR,
  output logic [31:0]            TR_REG_DATA,
  output logic [31:0]            TR_MEM_ADDR,
  output logic [31:0]            TR_MEM_DATA,
  output logic [$clog2(DEPTH):0] COUNT,
  output logic                   OVERFLOW,
  output logic [15:0]            DROPPED,
  output logic [CYC_W-1:0]       CYCLE,
  output logic                   HALTED
);

  localparam int DC_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef struct packed {
    logic [CYC_W-1:0] cycle;
    trace_payload_t   pl;
  } entry_t;

  trace_state_e     state_q, state_d;
  logic [DC_W-1:0]  dcnt_q, dcnt_d;
  logic [CYC_W-1:0] cycle_q, cycle_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      drop_q, drop_d;
  logic             ev_reg, ev_mem, ev_cap, pop_ok, drop;
  logic             fifo_full, fifo_empty;
  entry_t           ent_in, ent_out;

  // Event qualification and entry formation; writes to $0 are not events.
  always_comb begin
    ev_reg = REG_WEN_W && (REG_ADDR_W != 5'd0);
    ev_mem = MEM_WEN_M;
    ev_cap = (ev_reg || ev_mem) && (state_q != ST_HALTED);
    ent_in = '0;
    ent_in.cycle = cycle_q;
    if (ev_reg) begin
      ent_in.pl.kind     = ent_in.pl.kind | TR_REG;
      ent_in.pl.reg_addr = REG_ADDR_W;
      ent_in.pl.reg_data = REG_DATA_W;
    end
    if (ev_mem) begin
      ent_in.pl.kind     = ent_in.pl.kind | TR_MEM;
      ent_in.pl.mem_addr = MEM_ADDR_M;
      ent_in.pl.mem_data = MEM_DATA_M;
    end
    pop_ok = TR_READY && !fifo_empty;
    drop   = ev_cap && fifo_full && !pop_ok;
  end

  trace_fifo #(.DEPTH(DEPTH), .WIDTH($bits(entry_t))) u_fifo (
    .clk   (CLOCK),
    .rst_n (RESET),
    .push  (ev_cap),
    .pop   (TR_READY),
    .din   (ent_in),
    .dout  (ent_out),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (COUNT)
  );

  // Halt FSM next state: RUN -> DRAIN on the halt word, DRAIN -> HALTED when the
  // drain counter reaches zero; only reset leaves HALTED.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      ST_RUN: begin
        if (INST_F == HALT_INST) begin
          if (DRAIN_CYCLES <= 1) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_DRAIN;
            dcnt_d  = DC_W'(DRAIN_CYCLES - 1);
          end
        end
      end
      ST_DRAIN: begin
        dcnt_d = dcnt_q - DC_W'(1);
        if (dcnt_q <= DC_W'(1)) state_d = ST_HALTED;
      end
      default: ;
    endcase
  end

  // Cycle counter (saturating, frozen once halted) and drop statistics.
  always_comb begin
    cycle_d = cycle_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    if (state_q != ST_HALTED && cycle_q != '1) cycle_d = cycle_q + CYC_W'(1);
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end
  end

  // State and counter registers.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_RUN;
      dcnt_q  <= '0;
      cycle_q <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      cycle_q <= cycle_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  // Output mapping; head fields are already zero whenever the FIFO is empty.
  always_comb begin
    TR_VALID    = !fifo_empty;
    TR_KIND     = ent_out.pl.kind;
    TR_CYCLE    = ent_out.cycle;
    TR_REG_ADDR = ent_out.pl.reg_addr;
    TR_REG_DATA = ent_out.pl.reg_data;
    TR_MEM_ADDR = ent_out.pl.mem_addr;
    TR_MEM_DATA = ent_out.pl.mem_data;
    OVERFLOW    = ovf_q;
    DROPPED     = drop_q;
    CYCLE       = cycle_q;
    HALTED      = (state_q == ST_HALTED);
  end

endmodule
